muxreg_arbiter: RTL and testbench
=================================

// Module: muxreg_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer for the shared 8-input 16-bit mux register.
//   Picks one of 8 requesters and drives that register's load/sel for one cycle.
//   Tracks occupancy of the register output with a valid/ack handshake toward the consumer.
//   A timeout counter reclaims the register if the consumer never acks.
// PARAMETERS
//   TIMEOUT  16  max cycles q_valid may stay high without q_ack; 0 = no timeout
//   TO_W     8   width of wait counter; TIMEOUT must be <= 2**TO_W-1
// PORTS
//   CLK          in   1  clock, rising edge
//   RST          in   1  asynchronous reset, active-high
//   req          in   8  level request, bit i = requester i (drives mux input d<i>)
//   q_ack        in   1  consumer has taken mux-register q this cycle
//   load         out  1  to mux register load (combinational)
//   sel          out  3  to mux register sel (combinational); 0 when load=0
//   gnt          out  8  one-hot grant pulse, equals (load << sel)
//   q_valid      out  1  mux register q holds unconsumed data (registered)
//   q_src        out  3  index of requester whose data is in q (registered)
//   timeout_err  out  1  one-cycle pulse: q dropped on timeout (registered)
// BEHAVIOUR
//   - Reset (async, RST=1): ptr=0, q_valid=0, q_src=0, wait_cnt=0, timeout_err=0.
//     load/gnt are 0 while RST=1 irrespective of req.
//   - free = !q_valid | q_ack. load = free & |req_eff.
//   - Winner: first set bit of req_eff scanning ptr, ptr+1, ..., ptr+7 (mod 8).
//   - On edge with load=1: mux register captures d<sel>; q_valid<=1; q_src<=sel;
//     ptr<=sel+1 (mod 8, 7 wraps to 0); wait_cnt<=0.
//   - Latency: req seen in cycle T with free=1 -> gnt/load in T; q_valid and q in T+1.
//   - Requester handshake: gnt[i] pulse = data sampled. A req still high after gnt
//     is a new request, re-arbitrated with ptr already moved past i (fairness).
//   - Consumer handshake: data consumed on edge with q_valid & q_ack.
//     If no new load on that edge, q_valid<=0. Ack with new load: back-to-back,
//     q_valid stays 1, no bubble. q_ack while q_valid=0 is ignored.
//   - Timeout (TIMEOUT>0): wait_cnt++ each cycle q_valid & !q_ack.
//     On edge where wait_cnt==TIMEOUT-1 & !q_ack:
//     q_valid<=0, timeout_err<=1 for one cycle, wait_cnt<=0.
//     q_valid is therefore high exactly TIMEOUT cycles. No grant is issued on that edge;
//     earliest next grant is the following cycle. ptr is not changed by timeout.
//   - timeout_err is otherwise 0. q_src holds its value after q_valid falls.
//   - Mid-operation reset clears all state immediately.
//     Reset does not clear the mux register contents.
// CONFIGURATION
//   MUXARB_PRIO0_EN defined: req[0] has absolute priority; whenever req[0]=1 and free=1,
//     the winner is 0 regardless of ptr. ptr still updates to sel+1.
//     Requesters 1..7 stay round-robin among themselves.
//   Not defined: pure round-robin across all 8; req_eff = req.
// TESTING
//   1. RST=1 with req=8'hFF -> load=0, gnt=0, q_valid=0.
//      Release -> gnt=8'h01, sel=0 in first cycle.
//   2. req=8'hFF held, q_ack=1 always -> gnt sequence 01,02,04,...,80,01.
//      One grant per cycle; q_valid stays 1.
//   3. req=8'b0010_0100, ptr=3 -> first grant sel=5, then sel=2.
//      q_src follows one cycle later.
//   4. Single grant, q_ack=0, TIMEOUT=16 -> q_valid high 16 cycles, then 0.
//      timeout_err=1 for 1 cycle. No gnt during hold.
//   5. MUXARB_PRIO0_EN, req=8'h81 held, q_ack=1 -> gnt=01 every cycle.
//      Same without macro -> alternates 01,80.
//   6. Assert RST while q_valid=1 and wait_cnt=5 -> q_valid=0, timeout_err=0 at once.
//      First grant after release goes to lowest set req bit.

Source files
------------

// File: rtl/muxreg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : muxreg_arbiter                                                 |
// | Brief   : Round-robin load/sel sequencer for the shared 8:1 16-bit mux   |
// |           register, with valid/ack occupancy tracking and timeout.       |
// | Option  : `define MUXARB_PRIO0_EN gives requester 0 absolute priority.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module muxreg_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] req,
  input  logic       q_ack,
  output logic       load,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       q_valid,
  output logic [2:0] q_src,
  output logic       timeout_err
);

  localparam bit              c_TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  logic [2:0]      r_ptr;
  logic            r_q_valid;
  logic [2:0]      r_q_src;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout_err;

  logic [7:0] w_req_rr;
  logic [7:0] w_rot;
  logic [2:0] w_off;
  logic [2:0] w_rr_win;
  logic [2:0] w_win;
  logic       w_free;
  logic       w_load;

`ifdef MUXARB_PRIO0_EN
  // Requester 0 bypasses the rotation; 1..7 share the round-robin ring.
  assign w_req_rr = {req[7:1], 1'b0};
  assign w_win    = req[0] ? 3'd0 : w_rr_win;
`else
  assign w_req_rr = req;
  assign w_win    = w_rr_win;
`endif

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 8; i++) begin
      w_rot[i] = w_req_rr[r_ptr + 3'(i)];
    end
  end

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    w_off = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = 3'(i);
      end
    end
  end

  assign w_rr_win = r_ptr + w_off;
  assign w_free   = !r_q_valid || q_ack;
  assign w_load   = !RST && w_free && (|req);

  assign load        = w_load;
  assign sel         = w_load ? w_win : 3'd0;
  assign gnt         = {7'd0, w_load} << sel;
  assign q_valid     = r_q_valid;
  assign q_src       = r_q_src;
  assign timeout_err = r_timeout_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr         <= 3'd0;
      r_q_valid     <= 1'b0;
      r_q_src       <= 3'd0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (w_load) begin
        r_q_valid  <= 1'b1;
        r_q_src    <= sel;
        r_ptr      <= sel + 3'd1;
        r_wait_cnt <= '0;
      end else if (r_q_valid && q_ack) begin
        r_q_valid  <= 1'b0;
        r_wait_cnt <= '0;
      end else if (c_TO_EN && r_q_valid && (r_wait_cnt == c_TO_LAST)) begin
        // Consumer stalled too long: drop q so the register can be reused.
        r_q_valid     <= 1'b0;
        r_timeout_err <= 1'b1;
        r_wait_cnt    <= '0;
      end else if (r_q_valid) begin
        r_wait_cnt <= r_wait_cnt + TO_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muxreg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_muxreg_arbiter                                              |
// | Brief   : Directed self-checking bench for muxreg_arbiter.               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_muxreg_arbiter;

  logic       CLK;
  logic       RST;
  logic [7:0] req;
  logic       q_ack;
  logic       load;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       q_valid;
  logic [2:0] q_src;
  logic       timeout_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  muxreg_arbiter #(
    .TIMEOUT(16),
    .TO_W   (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .q_ack      (q_ack),
    .load       (load),
    .sel        (sel),
    .gnt        (gnt),
    .q_valid    (q_valid),
    .q_src      (q_src),
    .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e_gnt;
    logic [2:0] e_src;

    // Reset holds grants off even with every request raised
    RST = 1'b1; req = 8'hFF; q_ack = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_load",  32'(load), 32'd0);
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_qv",    32'(q_valid), 32'd0);
    check("rst_qsrc",  32'(q_src), 32'd0);
    check("rst_toerr", 32'(timeout_err), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; q_ack = 1'b1;
    @(negedge CLK);
    check("rel_gnt",  32'(gnt), 32'h01);
    check("rel_sel",  32'(sel), 32'd0);
    check("rel_load", 32'(load), 32'd1);

    // Full request mask with constant ack: one grant per cycle, rotating
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK); @(negedge CLK);
`ifdef MUXARB_PRIO0_EN
      e_gnt = 8'h01; e_src = 3'd0;
`else
      e_gnt = 8'h01 << (k % 8); e_src = 3'((k - 1) % 8);
`endif
      check("rr_gnt",  32'(gnt), 32'(e_gnt));
      check("rr_qsrc", 32'(q_src), 32'(e_src));
      check("rr_qv",   32'(q_valid), 32'd1);
    end

    // Move ptr to 3 by granting requester 2, then offer {5,2}
    @(posedge CLK); #1;
    RST = 1'b1; #1; RST = 1'b0;
    req = 8'h04; q_ack = 1'b1;
    @(negedge CLK);
    check("p3_gnt2", 32'(gnt), 32'h04);
    @(posedge CLK); #1;
    req = 8'b0010_0100;
    @(negedge CLK);
    check("p3_sel5",  32'(sel), 32'd5);
    check("p3_gnt5",  32'(gnt), 32'h20);
    check("p3_qsrc2", 32'(q_src), 32'd2);
    @(posedge CLK); @(negedge CLK);
    check("p3_sel2",  32'(sel), 32'd2);
    check("p3_qsrc5", 32'(q_src), 32'd5);
    @(posedge CLK); #1;

    // Requester 2 now owns q; consumer stalls while requester 0 waits
    req = 8'h01; q_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      check("to_hold_qv",  32'(q_valid), 32'd1);
      check("to_hold_gnt", 32'(gnt), 32'd0);
      check("to_hold_err", 32'(timeout_err), 32'd0);
      @(posedge CLK);
    end
    @(negedge CLK);
    check("to_drop_qv",  32'(q_valid), 32'd0);
    check("to_drop_err", 32'(timeout_err), 32'd1);
    check("to_drop_src", 32'(q_src), 32'd2);
    check("to_next_gnt", 32'(gnt), 32'h01);
    @(posedge CLK); #1;
    req = 8'h81;
    @(negedge CLK);
    check("to_err_pulse", 32'(timeout_err), 32'd0);
    check("to_regrant_qv", 32'(q_valid), 32'd1);
    check("to_regrant_src", 32'(q_src), 32'd0);
    check("to_busy_gnt", 32'(gnt), 32'd0);

    // Reset mid-hold with wait count at 5
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("mrst_qv",   32'(q_valid), 32'd0);
    check("mrst_err",  32'(timeout_err), 32'd0);
    check("mrst_load", 32'(load), 32'd0);
    check("mrst_gnt",  32'(gnt), 32'd0);
    @(negedge CLK);
    RST = 1'b0; q_ack = 1'b1;
    #1;
    check("mrst_first_gnt", 32'(gnt), 32'h01);

    // Requesters 0 and 7 contending with constant ack
    for (int j = 1; j <= 6; j++) begin
      @(posedge CLK); @(negedge CLK);
`ifdef MUXARB_PRIO0_EN
      e_gnt = 8'h01;
`else
      e_gnt = (j % 2 == 1) ? 8'h80 : 8'h01;
`endif
      check("p0_gnt", 32'(gnt), 32'(e_gnt));
      check("p0_qv",  32'(q_valid), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
